// File: rtl/mem_1r1w_arb_32x64.sv
// Two-client (A/B) round-robin arbiter in front of a 1R1W memory with 1-cycle read latency.
// Optional same-cycle write-to-read forwarding is enabled by defining MEM_ARB_BYPASS_EN.
module mem_1r1w_arb_32x64 #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int MASK_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_rd_valid,
  input  logic              b_rd_valid,
  output logic              a_rd_ready,
  output logic              b_rd_ready,
  input  logic [ADDR_W-1:0] a_rd_addr,
  input  logic [ADDR_W-1:0] b_rd_addr,
  output logic              a_rsp_valid,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_data,
  output logic [DATA_W-1:0] b_rsp_data,
  input  logic              a_wr_valid,
  input  logic              b_wr_valid,
  output logic              a_wr_ready,
  output logic              b_wr_ready,
  input  logic [ADDR_W-1:0] a_wr_addr,
  input  logic [ADDR_W-1:0] b_wr_addr,
  input  logic [DATA_W-1:0] a_wr_data,
  input  logic [DATA_W-1:0] b_wr_data,
  input  logic [MASK_W-1:0] a_wr_mask,
  input  logic [MASK_W-1:0] b_wr_mask,
  output logic [ADDR_W-1:0] R0_addr,
  output logic              R0_en,
  input  logic [DATA_W-1:0] R0_data,
  output logic [ADDR_W-1:0] W0_addr,
  output logic              W0_en,
  output logic [DATA_W-1:0] W0_data,
  output logic [MASK_W-1:0] W0_mask
);

  // Grant vectors: bit 0 = client A, bit 1 = client B. Pointer 0 favours A.
  logic [1:0]        w_rd_gnt;
  logic [1:0]        w_wr_gnt;
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic              r_tag_valid;
  logic              r_tag_id;
  logic [DATA_W-1:0] w_rsp_word;

  function automatic logic [1:0] rr_pick(input logic req_a, input logic req_b, input logic ptr);
    logic [1:0] gnt;
    gnt = 2'b00;
    if (req_a && req_b) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end else if (req_a) begin
      gnt = 2'b01;
    end else if (req_b) begin
      gnt = 2'b10;
    end else begin
      gnt = 2'b00;
    end
    return gnt;
  endfunction

  // Independent read and write arbitration; nothing is granted while in reset.
  always_comb begin
    w_rd_gnt = 2'b00;
    w_wr_gnt = 2'b00;
    if (reset) begin
      w_rd_gnt = 2'b00;
      w_wr_gnt = 2'b00;
    end else begin
      w_rd_gnt = rr_pick(a_rd_valid, b_rd_valid, r_rd_ptr);
      w_wr_gnt = rr_pick(a_wr_valid, b_wr_valid, r_wr_ptr);
    end
  end

  assign a_rd_ready = w_rd_gnt[0];
  assign b_rd_ready = w_rd_gnt[1];
  assign a_wr_ready = w_wr_gnt[0];
  assign b_wr_ready = w_wr_gnt[1];

  assign R0_en   = w_rd_gnt[0] | w_rd_gnt[1];
  assign R0_addr = w_rd_gnt[1] ? b_rd_addr : a_rd_addr;
  assign W0_en   = w_wr_gnt[0] | w_wr_gnt[1];
  assign W0_addr = w_wr_gnt[1] ? b_wr_addr : a_wr_addr;
  assign W0_data = w_wr_gnt[1] ? b_wr_data : a_wr_data;
  assign W0_mask = w_wr_gnt[1] ? b_wr_mask : a_wr_mask;

  // Round-robin pointers: after a grant, point at the client that was not served.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      r_rd_ptr <= (w_rd_gnt != 2'b00) ? w_rd_gnt[0] : r_rd_ptr;
      r_wr_ptr <= (w_wr_gnt != 2'b00) ? w_wr_gnt[0] : r_wr_ptr;
    end
  end

  // Response tag: which client owns the memory data returning next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tag_valid <= 1'b0;
      r_tag_id    <= 1'b0;
    end else begin
      r_tag_valid <= R0_en;
      r_tag_id    <= w_rd_gnt[1];
    end
  end

`ifdef MEM_ARB_BYPASS_EN
  logic              r_byp_hit;
  logic [DATA_W-1:0] r_byp_data;
  logic [MASK_W-1:0] r_byp_mask;

  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [MASK_W-1:0] mask);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MASK_W; i++) begin
      if (mask[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Capture a same-cycle, same-address write so the read response sees it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_byp_hit  <= 1'b0;
      r_byp_data <= {DATA_W{1'b0}};
      r_byp_mask <= {MASK_W{1'b0}};
    end else begin
      r_byp_hit  <= R0_en & W0_en & (R0_addr == W0_addr);
      r_byp_data <= W0_data;
      r_byp_mask <= W0_mask;
    end
  end

  // Forwarded response word.
  always_comb begin
    w_rsp_word = R0_data;
    if (r_byp_hit) begin
      w_rsp_word = byte_merge(R0_data, r_byp_data, r_byp_mask);
    end else begin
      w_rsp_word = R0_data;
    end
  end
`else
  assign w_rsp_word = R0_data;
`endif

  assign a_rsp_valid = r_tag_valid & ~r_tag_id & ~reset;
  assign b_rsp_valid = r_tag_valid &  r_tag_id & ~reset;
  assign a_rsp_data  = a_rsp_valid ? w_rsp_word : {DATA_W{1'b0}};
  assign b_rsp_data  = b_rsp_valid ? w_rsp_word : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_1r1w_arb_32x64.sv
// Self-checking bench for mem_1r1w_arb_32x64: includes a read-first SRAM model and
// a behavioural reference (pointer rules + word array) driven with random traffic.
module tb_mem_1r1w_arb_32x64;
  logic        clock;
  logic        reset;
  logic        a_rd_valid, b_rd_valid, a_rd_ready, b_rd_ready;
  logic [4:0]  a_rd_addr, b_rd_addr;
  logic        a_rsp_valid, b_rsp_valid;
  logic [63:0] a_rsp_data, b_rsp_data;
  logic        a_wr_valid, b_wr_valid, a_wr_ready, b_wr_ready;
  logic [4:0]  a_wr_addr, b_wr_addr;
  logic [63:0] a_wr_data, b_wr_data;
  logic [7:0]  a_wr_mask, b_wr_mask;
  logic [4:0]  R0_addr, W0_addr;
  logic        R0_en, W0_en;
  logic [63:0] R0_data, W0_data;
  logic [7:0]  W0_mask;

  int total = 0;
  int bad   = 0;

  mem_1r1w_arb_32x64 dut (
    .clock(clock), .reset(reset),
    .a_rd_valid(a_rd_valid), .b_rd_valid(b_rd_valid),
    .a_rd_ready(a_rd_ready), .b_rd_ready(b_rd_ready),
    .a_rd_addr(a_rd_addr), .b_rd_addr(b_rd_addr),
    .a_rsp_valid(a_rsp_valid), .b_rsp_valid(b_rsp_valid),
    .a_rsp_data(a_rsp_data), .b_rsp_data(b_rsp_data),
    .a_wr_valid(a_wr_valid), .b_wr_valid(b_wr_valid),
    .a_wr_ready(a_wr_ready), .b_wr_ready(b_wr_ready),
    .a_wr_addr(a_wr_addr), .b_wr_addr(b_wr_addr),
    .a_wr_data(a_wr_data), .b_wr_data(b_wr_data),
    .a_wr_mask(a_wr_mask), .b_wr_mask(b_wr_mask),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Read-first SRAM environment model.
  logic [63:0] sram [0:31];
  always @(posedge clock) begin
    if (R0_en) R0_data <= sram[R0_addr];
    if (W0_en) begin
      for (int i = 0; i < 8; i++)
        if (W0_mask[i]) sram[W0_addr][8*i +: 8] <= W0_data[8*i +: 8];
    end
  end

  // Reference model state: client 0 = A, 1 = B, -1 = nobody.
  logic [63:0] ref_mem [0:31];
  int          m_rd_ptr, m_wr_ptr;
  bit          pend_v;
  int          pend_c;
  logic [63:0] pend_d;
  int          e_rg, e_wg;
  bit          e_arv, e_brv;
  logic [63:0] e_ad, e_bd;

  function automatic int pick(input bit rst, input bit va, input bit vb, input int ptr);
    if (rst) return -1;
    if (va && vb) return ptr;
    if (va) return 0;
    if (vb) return 1;
    return -1;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old_w;
    for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic model_eval();
    e_rg  = pick(reset, a_rd_valid, b_rd_valid, m_rd_ptr);
    e_wg  = pick(reset, a_wr_valid, b_wr_valid, m_wr_ptr);
    e_arv = !reset && pend_v && pend_c == 0;
    e_brv = !reset && pend_v && pend_c == 1;
    e_ad  = e_arv ? pend_d : 64'h0;
    e_bd  = e_brv ? pend_d : 64'h0;
  endtask

  task automatic model_commit();
    logic [4:0]  ra, wa;
    logic [63:0] wd;
    logic [7:0]  wm;
    model_eval();
    if (reset) begin
      m_rd_ptr = 0; m_wr_ptr = 0; pend_v = 1'b0;
    end else begin
      ra = (e_rg == 1) ? b_rd_addr : a_rd_addr;
      wa = (e_wg == 1) ? b_wr_addr : a_wr_addr;
      wd = (e_wg == 1) ? b_wr_data : a_wr_data;
      wm = (e_wg == 1) ? b_wr_mask : a_wr_mask;
      pend_v = (e_rg >= 0);
      pend_c = e_rg;
      pend_d = ref_mem[ra];
`ifdef MEM_ARB_BYPASS_EN
      if (e_rg >= 0 && e_wg >= 0 && ra == wa) pend_d = merge(pend_d, wd, wm);
`endif
      if (e_wg >= 0) ref_mem[wa] = merge(ref_mem[wa], wd, wm);
      if (e_rg >= 0) m_rd_ptr = 1 - e_rg;
      if (e_wg >= 0) m_wr_ptr = 1 - e_wg;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic idle();
    a_rd_valid = 1'b0; b_rd_valid = 1'b0; a_wr_valid = 1'b0; b_wr_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_rd_valid = 1'b1; b_rd_valid = 1'b1; a_wr_valid = 1'b1; b_wr_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      total++;
      if ({a_rd_ready, b_rd_ready, a_wr_ready, b_wr_ready, R0_en, W0_en, a_rsp_valid, b_rsp_valid} !== 8'h00) begin
        bad++;
        $display("FAIL reset_outputs got=%b exp=00000000",
                 {a_rd_ready, b_rd_ready, a_wr_ready, b_wr_ready, R0_en, W0_en, a_rsp_valid, b_rsp_valid});
      end
      tick();
    end
    do_reset();
  endtask

  task automatic test_write_then_read();
    do_reset();
    a_wr_valid = 1'b1; a_wr_addr = 5'd3; a_wr_data = 64'h1122334455667788; a_wr_mask = 8'hFF;
    @(negedge clock);
    total++;
    if (a_wr_ready !== 1'b1 || W0_en !== 1'b1 || W0_addr !== 5'd3) begin
      bad++; $display("FAIL wr_grant got=%b%b addr=%0d exp=11 addr=3", a_wr_ready, W0_en, W0_addr);
    end
    tick();
    idle(); b_rd_valid = 1'b1; b_rd_addr = 5'd3;
    @(negedge clock);
    total++;
    if (b_rd_ready !== 1'b1 || R0_en !== 1'b1) begin
      bad++; $display("FAIL rd_grant got=%b%b exp=11", b_rd_ready, R0_en);
    end
    tick();
    idle();
    @(negedge clock);
    total++;
    if (b_rsp_valid !== 1'b1 || a_rsp_valid !== 1'b0 || b_rsp_data !== 64'h1122334455667788) begin
      bad++; $display("FAIL wr_rd_rsp got=%b%b %h exp=01 1122334455667788", a_rsp_valid, b_rsp_valid, b_rsp_data);
    end
    tick();
  endtask

  task automatic test_bypass();
    logic [63:0] exp_d;
`ifdef MEM_ARB_BYPASS_EN
    exp_d = 64'h00000000FFFFFFFF;
`else
    exp_d = 64'h0;
`endif
    do_reset();
    a_wr_valid = 1'b1; a_wr_addr = 5'd7; a_wr_data = 64'hFFFFFFFFFFFFFFFF; a_wr_mask = 8'h0F;
    b_rd_valid = 1'b1; b_rd_addr = 5'd7;
    @(negedge clock);
    total++;
    if (a_wr_ready !== 1'b1 || b_rd_ready !== 1'b1) begin
      bad++; $display("FAIL same_cycle_grant got=%b%b exp=11", a_wr_ready, b_rd_ready);
    end
    tick();
    idle();
    @(negedge clock);
    total++;
    if (b_rsp_valid !== 1'b1 || b_rsp_data !== exp_d) begin
      bad++; $display("FAIL bypass_rsp got=%b %h exp=1 %h", b_rsp_valid, b_rsp_data, exp_d);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i < 4) begin
        a_rd_valid = 1'b1; a_rd_addr = 5'd3; b_rd_valid = 1'b1; b_rd_addr = 5'd7;
      end
      @(negedge clock);
      if (i < 4) begin
        total++;
        if (a_rd_ready !== (i % 2 == 0) || b_rd_ready !== (i % 2 == 1)) begin
          bad++; $display("FAIL b2b_grant%0d got=%b%b exp=%b%b", i, a_rd_ready, b_rd_ready, i % 2 == 0, i % 2 == 1);
        end
      end
      if (i > 0) begin
        total++;
        if (a_rsp_valid !== ((i - 1) % 2 == 0) || b_rsp_valid !== ((i - 1) % 2 == 1) ||
            (a_rsp_valid && a_rsp_data !== 64'h1122334455667788) ||
            (b_rsp_valid && b_rsp_data !== ref_mem[7])) begin
          bad++; $display("FAIL b2b_rsp%0d got=%b%b a=%h b=%h", i, a_rsp_valid, b_rsp_valid, a_rsp_data, b_rsp_data);
        end
      end
      tick();
    end
  endtask

  task automatic test_single_writer();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      b_wr_valid = 1'b1; b_wr_addr = 5'(10 + i); b_wr_data = {$urandom, $urandom}; b_wr_mask = 8'hFF;
      @(negedge clock);
      total++;
      if (b_wr_ready !== 1'b1 || a_wr_ready !== 1'b0 || W0_en !== 1'b1 || W0_addr !== 5'(10 + i)) begin
        bad++; $display("FAIL single_writer%0d got=%b%b%b addr=%0d exp=101 addr=%0d",
                        i, a_wr_ready, b_wr_ready, W0_en, W0_addr, 10 + i);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_kills_rsp();
    do_reset();
    a_rd_valid = 1'b1; a_rd_addr = 5'd1; a_wr_valid = 1'b1; a_wr_addr = 5'd2;
    a_wr_data = 64'h0; a_wr_mask = 8'h00;
    @(negedge clock);
    total++;
    if (a_rd_ready !== 1'b1 || a_wr_ready !== 1'b1) begin
      bad++; $display("FAIL rst_kill_grant got=%b%b exp=11", a_rd_ready, a_wr_ready);
    end
    tick();
    idle(); reset = 1'b1;
    @(negedge clock);
    total++;
    if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_kill_rsp got=%b%b exp=00", a_rsp_valid, b_rsp_valid);
    end
    tick();
    reset = 1'b0;
    a_rd_valid = 1'b1; b_rd_valid = 1'b1; a_wr_valid = 1'b1; b_wr_valid = 1'b1;
    @(negedge clock);
    total++;
    if ({a_rd_ready, b_rd_ready, a_wr_ready, b_wr_ready} !== 4'b1010) begin
      bad++; $display("FAIL rst_ptr got=%b exp=1010", {a_rd_ready, b_rd_ready, a_wr_ready, b_wr_ready});
    end
    tick();
    idle(); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset      = ($urandom_range(0, 39) == 0);
      a_rd_valid = $urandom_range(0, 1); b_rd_valid = $urandom_range(0, 1);
      a_wr_valid = $urandom_range(0, 1); b_wr_valid = $urandom_range(0, 1);
      a_rd_addr  = 5'($urandom_range(0, 7)); b_rd_addr = 5'($urandom_range(0, 7));
      a_wr_addr  = 5'($urandom_range(0, 7)); b_wr_addr = 5'($urandom_range(0, 7));
      a_wr_data  = {$urandom, $urandom}; b_wr_data = {$urandom, $urandom};
      a_wr_mask  = 8'($urandom); b_wr_mask = 8'($urandom);
      @(negedge clock);
      model_eval();
      total++;
      if ({a_rd_ready, b_rd_ready, a_wr_ready, b_wr_ready, a_rsp_valid, b_rsp_valid} !==
          {e_rg == 0, e_rg == 1, e_wg == 0, e_wg == 1, e_arv, e_brv}) begin
        bad++; $display("FAIL rand_ctrl c=%0d got=%b exp=%b", c,
                        {a_rd_ready, b_rd_ready, a_wr_ready, b_wr_ready, a_rsp_valid, b_rsp_valid},
                        {e_rg == 0, e_rg == 1, e_wg == 0, e_wg == 1, e_arv, e_brv});
      end
      total++;
      if (R0_en !== (e_rg >= 0) || (e_rg >= 0 && R0_addr !== (e_rg == 1 ? b_rd_addr : a_rd_addr))) begin
        bad++; $display("FAIL rand_r0 c=%0d got=%b %0d", c, R0_en, R0_addr);
      end
      total++;
      if (W0_en !== (e_wg >= 0) || (e_wg >= 0 &&
          ({W0_addr, W0_data, W0_mask} !== (e_wg == 1 ? {b_wr_addr, b_wr_data, b_wr_mask}
                                                       : {a_wr_addr, a_wr_data, a_wr_mask})))) begin
        bad++; $display("FAIL rand_w0 c=%0d got=%b %0d %h %h", c, W0_en, W0_addr, W0_data, W0_mask);
      end
      total++;
      if (a_rsp_data !== e_ad || b_rsp_data !== e_bd) begin
        bad++; $display("FAIL rand_rsp c=%0d got=%h %h exp=%h %h", c, a_rsp_data, b_rsp_data, e_ad, e_bd);
      end
      tick();
    end
    reset = 1'b0;
    idle();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      sram[i] = 64'h0; ref_mem[i] = 64'h0;
    end
    m_rd_ptr = 0; m_wr_ptr = 0; pend_v = 1'b0; pend_c = 0; pend_d = 64'h0;
    reset = 1'b1;
    idle();
    a_rd_addr = 5'd0; b_rd_addr = 5'd0; a_wr_addr = 5'd0; b_wr_addr = 5'd0;
    a_wr_data = 64'h0; b_wr_data = 64'h0; a_wr_mask = 8'h00; b_wr_mask = 8'h00;
    #1;
    test_reset();
    test_write_then_read();
    test_bypass();
    test_back_to_back();
    test_single_writer();
    test_reset_kills_rsp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_1r1w_arb_32x64.md
MEM_1R1W_ARB_32X64 -- requirements
Module: mem_1r1w_arb_32x64

Interface
REQ-001 Parameter ADDR_W, default 5, memory word-address width (32 words).
REQ-002 Parameter DATA_W, default 64, memory word width in bits.
REQ-003 Parameter MASK_W, default 8, write-mask width (byte granularity, DATA_W/8).
REQ-004 Port clock, input, 1, single clock for all logic; the memory's R0_clk and W0_clk are tied to it outside this block.
REQ-005 Port reset, input, 1, synchronous, active-high reset.
REQ-006 Ports a_rd_valid, b_rd_valid, input, 1, client A/B read request.
REQ-007 Ports a_rd_ready, b_rd_ready, output, 1, read grant (request accepted this cycle).
REQ-008 Ports a_rd_addr, b_rd_addr, input, ADDR_W, read address.
REQ-009 Ports a_rsp_valid, b_rsp_valid, output, 1, read data valid.
REQ-010 Ports a_rsp_data, b_rsp_data, output, DATA_W, read data.
REQ-011 Ports a_wr_valid, b_wr_valid, input, 1, client A/B write request.
REQ-012 Ports a_wr_ready, b_wr_ready, output, 1, write grant.
REQ-013 Ports a_wr_addr, b_wr_addr, input, ADDR_W, write address.
REQ-014 Ports a_wr_data, b_wr_data, input, DATA_W, write data.
REQ-015 Ports a_wr_mask, b_wr_mask, input, MASK_W, byte enables (bit i covers data[8i+7:8i]).
REQ-016 Ports R0_addr output ADDR_W, R0_en output 1 (active-high), R0_data input DATA_W; memory read port.
REQ-017 Ports W0_addr output ADDR_W, W0_en output 1 (active-high), W0_data output DATA_W, W0_mask output MASK_W; memory write port.

Function
REQ-018 Read and write ports SHALL be arbitrated independently; one read and one write can be granted in the same cycle.
REQ-019 Each port SHALL use a 1-bit round-robin pointer: the pointed-to client has priority; after a grant the pointer SHALL move to the other client.
REQ-020 If only one client requests, it SHALL be granted regardless of the pointer; with no request the pointer SHALL hold.
REQ-021 Ready SHALL be combinational from valid and the pointer; at most one of a_rd_ready/b_rd_ready (and a_wr_ready/b_wr_ready) SHALL be high per cycle.
REQ-022 A read grant SHALL drive R0_en=1 and R0_addr to the granted address in the same cycle; with no grant, R0_en=0.
REQ-023 A write grant SHALL drive W0_en=1 and W0_addr/W0_data/W0_mask from the granted client in the same cycle; with no grant, W0_en=0.
REQ-024 Read latency SHALL be exactly 1 cycle: <x>_rsp_valid is high for one cycle, the cycle after the grant, only for the granted client; rsp_data = R0_data in that cycle (subject to REQ-030).
REQ-025 The block SHALL hold a registered response tag (valid bit and client id) and SHALL issue no back-pressure on responses.
REQ-026 Back-to-back reads SHALL sustain one grant per cycle; alternating A/B when both request continuously.
REQ-027 A write SHALL be visible to any read granted in a later cycle.
REQ-028 rsp_data SHALL be 0 whenever rsp_valid is 0.

Reset
REQ-029 While reset is high: both pointers = client A, all ready outputs 0, R0_en=0, W0_en=0, rsp_valid=0, response tag cleared; a read granted in the cycle before reset asserts SHALL produce no response.

Configuration
REQ-030 Macro MEM_ARB_BYPASS_EN: when defined, if a read and a write are granted in the same cycle to the same address, the response SHALL be the per-byte merge (mask bit 1 -> write byte, 0 -> R0_data byte), using registered write data, mask and address-match flag.
REQ-031 When MEM_ARB_BYPASS_EN is undefined, the response SHALL equal R0_data unmodified and the bypass registers SHALL be absent.

Verification
REQ-032 After reset, A writes addr 3 data 0x1122334455667788 mask 0xFF; next cycle B reads addr 3 -> b_rd_ready=1, b_rsp_valid the following cycle with data 0x1122334455667788, a_rsp_valid=0.
REQ-033 A and B hold rd_valid high 4 cycles -> grants A,B,A,B; responses return to A,B,A,B one cycle later.
REQ-034 Same-cycle A write addr 7 data 0xFFFFFFFFFFFFFFFF mask 0x0F, B read addr 7 with old word 0 -> with MEM_ARB_BYPASS_EN b_rsp_data=0x00000000FFFFFFFF; without it b_rsp_data=0.
REQ-035 Only B requests writes for 3 cycles while pointer is at A -> b_wr_ready=1 every cycle, W0_en=1 each cycle.
REQ-036 Read granted to A in cycle N, reset high in cycle N+1 -> a_rsp_valid=0 in N+1, both pointers = A afterwards.
